// File: rtl/ysyx_220066_div_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_220066_div_ctrl_pkg
//
// Purpose : Definitions shared by the divider sequencer, its corner-case
//           unit and its bench. It holds the controller state encoding, the
//           bit positions inside the 2-bit op field, and the most-negative
//           integer constants used to detect signed overflow.
//
// Contents:
//   state_t      IDLE / ISSUE / BUSY / DRAIN / DONE
//   OP_UNSIGNED  bit index of the unsigned flag in req_op / div_aluctr
//   OP_REM       bit index of the remainder flag in req_op / div_aluctr
//   INT64_MIN    64-bit most-negative value
//   INT32_MIN    32-bit most-negative value
//   sext32()     sign-extend a 32-bit value to 64 bits
// ----------------------------------------------------------------------------
package ysyx_220066_div_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,   // waiting for an op from EX
        ISSUE = 3'd1,   // presenting operands to the divider
        BUSY  = 3'd2,   // divider working on a live op
        DRAIN = 3'd3,   // divider working on a flushed op, result discarded
        DONE  = 3'd4    // result held until writeback takes it
    } state_t;

    localparam int OP_UNSIGNED = 0;
    localparam int OP_REM      = 1;

    localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_220066_div_ctrl_if.sv
// ----------------------------------------------------------------------------
// ysyx_220066_div_ctrl_if
//
// Purpose : Bundles every handshake and data signal of the divider sequencer:
//           the request channel from EX, the response channel to writeback,
//           the flush line, and the channel to/from the iterative divider.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clk edge where both valid and ready are high. Once valid is raised,
// the payload stays stable until that transfer (or a flush/reset kills it).
// div_out_valid is the exception: it is a one-cycle pulse with no ready.
//
// Parameters:
//   TAG_W   width of the writeback tag
//
// Modports:
//   slave   the controller (ysyx_220066_div_ctrl)
//   master  its environment (EX, writeback, flush source and divider)
// ----------------------------------------------------------------------------
interface ysyx_220066_div_ctrl_if #(
    parameter int TAG_W = 5
);
    // Request channel (EX -> controller)
    logic             req_valid;
    logic             req_ready;
    logic [63:0]      req_src1;
    logic [63:0]      req_src2;
    logic             req_is_w;
    logic [1:0]       req_op;
    logic [TAG_W-1:0] req_tag;

    // Pipeline kill
    logic             flush;

    // Response channel (controller -> writeback)
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;

    // Divider channel
    logic             div_in_valid;
    logic             div_in_ready;
    logic [63:0]      div_src1;
    logic [63:0]      div_src2;
    logic             div_is_w;
    logic [1:0]       div_aluctr;
    logic             div_out_valid;
    logic [63:0]      div_result;

    modport slave (
        input  req_valid, req_src1, req_src2, req_is_w, req_op, req_tag,
        input  flush,
        input  rsp_ready,
        input  div_in_ready, div_out_valid, div_result,
        output req_ready,
        output rsp_valid, rsp_result, rsp_tag,
        output div_in_valid, div_src1, div_src2, div_is_w, div_aluctr
    );

    modport master (
        output req_valid, req_src1, req_src2, req_is_w, req_op, req_tag,
        output flush,
        output rsp_ready,
        output div_in_ready, div_out_valid, div_result,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_tag,
        input  div_in_valid, div_src1, div_src2, div_is_w, div_aluctr
    );

endinterface

// File: rtl/ysyx_220066_div_special.sv
// ----------------------------------------------------------------------------
// ysyx_220066_div_special
//
// Purpose : Purely combinational detection of the RV64 division corner cases
//           that the iterative divider is never asked to handle, together
//           with their architectural result.
//             - divide by zero : quotient = all ones, remainder = dividend
//             - signed overflow: MIN / -1 gives quotient = MIN, remainder = 0
//           For W forms only the low 32 bits of the operands are examined
//           and results are sign-extended from bit 31.
//
// Ports:
//   src1    in  64  dividend
//   src2    in  64  divisor
//   is_w    in  1   32-bit form
//   op      in  2   [OP_UNSIGNED]=unsigned, [OP_REM]=remainder
//   hit     out 1   operands form a corner case
//   result  out 64  final result when hit (0 otherwise)
// ----------------------------------------------------------------------------
module ysyx_220066_div_special
    import ysyx_220066_div_ctrl_pkg::*;
(
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic        is_w,
    input  logic [1:0]  op,
    output logic        hit,
    output logic [63:0] result
);

    logic        div_zero;
    logic        overflow;
    logic [63:0] src1_ext;

    always_comb begin
        div_zero = 1'b0;
        overflow = 1'b0;
        src1_ext = src1;
        hit      = 1'b0;
        result   = '0;

        if (is_w) begin
            div_zero = (src2[31:0] == 32'd0);
            overflow = !op[OP_UNSIGNED] &&
                       (src1[31:0] == INT32_MIN) &&
                       (src2[31:0] == 32'hFFFF_FFFF);
            src1_ext = sext32(src1[31:0]);
        end else begin
            div_zero = (src2 == 64'd0);
            overflow = !op[OP_UNSIGNED] &&
                       (src1 == INT64_MIN) &&
                       (src2 == 64'hFFFF_FFFF_FFFF_FFFF);
        end

        // Divide-by-zero takes precedence; the two cases cannot overlap
        // anyway because overflow needs a divisor of -1.
        if (div_zero) begin
            hit    = 1'b1;
            result = op[OP_REM] ? src1_ext : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (overflow) begin
            hit    = 1'b1;
            result = op[OP_REM] ? 64'd0 : src1_ext;
        end
    end

endmodule

// File: rtl/ysyx_220066_div_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_220066_div_ctrl
//
// Purpose : Sequencer between EX/MDU issue and the iterative 64-bit divider
//           (DIV/DIVU/REM/REMU and their W forms).
//             - Corner cases (divide by zero, signed overflow) complete in a
//               one-cycle fast path without touching the divider.
//             - The divider cannot abort, so an op flushed while the divider
//               owns it is drained and its result thrown away.
//             - The result is held in DONE until writeback accepts it.
//
// Parameters:
//   TAG_W        width of the writeback tag carried with each op
//
// Configuration macro:
//   DIV_RESULT_CACHE_EN  when defined, a one-entry cache remembers the last
//                        divider result keyed on {src1,src2,is_w,op}; a key
//                        match at accept completes in one cycle. The entry is
//                        refilled on every divider result (also while
//                        draining) and invalidated only by rst.
//
// Ports:
//   clk         in   1        clock
//   rst         in   1        synchronous, active-high reset
//   bus         slave         request, response, flush and divider channels
//                             (see ysyx_220066_div_ctrl_if)
//   busy        out  1        state != IDLE
//   dbg_state   out  state_t  current FSM state
//
// Output behaviour:
//   req_ready     = IDLE && !flush (flush beats a same-cycle request)
//   rsp_valid     = DONE
//   div_in_valid  = ISSUE
//   div_* operands, rsp_result and rsp_tag come straight from registers.
// ----------------------------------------------------------------------------
module ysyx_220066_div_ctrl
    import ysyx_220066_div_ctrl_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_220066_div_ctrl_if.slave bus,
    output logic                  busy,
    output state_t                dbg_state
);

    // ------------------------------------------------------------------
    // State and captured op
    // ------------------------------------------------------------------
    state_t           state;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      src1_q;
    logic [63:0]      src2_q;
    logic             is_w_q;
    logic [1:0]       op_q;
    logic [63:0]      result_q;

    logic             accept;
    logic             spec_hit;
    logic [63:0]      spec_result;
    logic [63:0]      div_final;
    logic             cache_hit;
    logic [63:0]      cache_result;

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    assign bus.req_ready    = (state == IDLE) && !bus.flush;
    assign accept           = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid    = (state == DONE);
    assign bus.rsp_result   = result_q;
    assign bus.rsp_tag      = tag_q;

    assign bus.div_in_valid = (state == ISSUE);
    assign bus.div_src1     = src1_q;
    assign bus.div_src2     = src2_q;
    assign bus.div_is_w     = is_w_q;
    assign bus.div_aluctr   = op_q;

    assign busy             = (state != IDLE);
    assign dbg_state        = state;

    // The divider may leave junk above bit 31 for W forms; the architectural
    // result is always the sign extension of the low word.
    assign div_final = is_w_q ? sext32(bus.div_result[31:0]) : bus.div_result;

    // ------------------------------------------------------------------
    // Corner-case fast path, evaluated on the live request
    // ------------------------------------------------------------------
    ysyx_220066_div_special u_special (
        .src1   (bus.req_src1),
        .src2   (bus.req_src2),
        .is_w   (bus.req_is_w),
        .op     (bus.req_op),
        .hit    (spec_hit),
        .result (spec_result)
    );

    // ------------------------------------------------------------------
    // Optional one-entry result cache
    // ------------------------------------------------------------------
`ifdef DIV_RESULT_CACHE_EN
    logic [63:0] c_src1;
    logic [63:0] c_src2;
    logic        c_is_w;
    logic [1:0]  c_op;
    logic [63:0] c_result;
    logic        c_valid;
    logic        div_done;

    // A divider result only counts while the divider actually owns an op;
    // pulses in any other state are protocol errors and are ignored.
    assign div_done = bus.div_out_valid && ((state == BUSY) || (state == DRAIN));

    // The key comes from the registered operands, which are still the ones
    // the divider is working on, including for a flushed (draining) op.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid  <= 1'b0;
            c_src1   <= '0;
            c_src2   <= '0;
            c_is_w   <= 1'b0;
            c_op     <= '0;
            c_result <= '0;
        end else if (div_done) begin
            c_valid  <= 1'b1;
            c_src1   <= src1_q;
            c_src2   <= src2_q;
            c_is_w   <= is_w_q;
            c_op     <= op_q;
            c_result <= div_final;
        end
    end

    assign cache_hit    = c_valid &&
                          (c_src1 == bus.req_src1) &&
                          (c_src2 == bus.req_src2) &&
                          (c_is_w == bus.req_is_w) &&
                          (c_op   == bus.req_op);
    assign cache_result = c_result;
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tag_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            is_w_q   <= 1'b0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        tag_q  <= bus.req_tag;
                        src1_q <= bus.req_src1;
                        src2_q <= bus.req_src2;
                        is_w_q <= bus.req_is_w;
                        op_q   <= bus.req_op;
                        if (spec_hit) begin
                            result_q <= spec_result;
                            state    <= DONE;
                        end else if (cache_hit) begin
                            result_q <= cache_result;
                            state    <= DONE;
                        end else begin
                            state    <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    // A flush here wins over div_in_ready, so the divider
                    // never starts on a killed op.
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (bus.div_in_ready) begin
                        state <= BUSY;
                    end
                end

                BUSY: begin
                    if (bus.div_out_valid) begin
                        // A flush arriving together with the result has
                        // nothing left to drain: drop the result and go idle.
                        if (bus.flush) begin
                            state <= IDLE;
                        end else begin
                            result_q <= div_final;
                            state    <= DONE;
                        end
                    end else if (bus.flush) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (bus.div_out_valid) begin
                        state <= IDLE;
                    end
                end

                DONE: begin
                    // Flush drops the result even when writeback is ready in
                    // the same cycle; the tb/writeback side must also ignore
                    // that handshake.
                    if (bus.flush || bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220066_div_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_220066_div_ctrl
//
// Bench for the divider sequencer. A behavioural divider answers the
// controller with random accept delay and latency; a reference model
// computes every RV64 division result with plain arithmetic. Expected
// {tag,result} words are queued at accept time and a monitor pops them on
// each response handshake.
// ----------------------------------------------------------------------------
module tb_ysyx_220066_div_ctrl;
    import ysyx_220066_div_ctrl_pkg::*;

    localparam int TAG_W = 5;
    localparam int EW    = 64 + TAG_W;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_220066_div_ctrl_if #(.TAG_W(TAG_W)) bus ();
    logic   busy;
    state_t dbg_state;

    ysyx_220066_div_ctrl #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // Divider model controls
    int lat_lo      = 0;
    int lat_hi      = 12;
    bit div_hold    = 1'b0;
    int div_accepts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out / unexpected event", name);
    endtask

    // ------------------------------------------------------------------
    // Reference model: RV64 M-extension division semantics
    // ------------------------------------------------------------------
    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input logic w, input logic [1:0] op);
        longint          sa, sb, sr;
        longint unsigned ua, ub;
        int              xa, xb, xr;
        int unsigned     wa, wb;
        logic [63:0]     res;
        if (w) begin
            xa = a[31:0];
            xb = b[31:0];
            wa = a[31:0];
            wb = b[31:0];
            if (xb == 0)
                xr = op[1] ? xa : -1;
            else if (!op[0] && xa == 32'sh8000_0000 && xb == -1)
                xr = op[1] ? 0 : xa;
            else if (op[0])
                xr = op[1] ? int'(wa % wb) : int'(wa / wb);
            else
                xr = op[1] ? (xa % xb) : (xa / xb);
            res = {{32{xr[31]}}, xr};
        end else begin
            sa = a;
            sb = b;
            ua = a;
            ub = b;
            if (sb == 0)
                sr = op[1] ? sa : -64'sd1;
            else if (!op[0] && sa == 64'sh8000_0000_0000_0000 && sb == -64'sd1)
                sr = op[1] ? 64'sd0 : sa;
            else if (op[0])
                sr = op[1] ? longint'(ua % ub) : longint'(ua / ub);
            else
                sr = op[1] ? (sa % sb) : (sa / sb);
            res = sr;
        end
        return res;
    endfunction

    // True when the op is a divide-by-zero or signed overflow.
    function automatic logic is_corner(input logic [63:0] a, input logic [63:0] b,
                                       input logic w, input logic [1:0] op);
        if (w)
            return (b[31:0] == 32'd0) ||
                   (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) ||
               (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    function automatic logic [63:0] rnd_operand(input bit divisor);
        case ($urandom_range(0, 5))
            0: return divisor ? 64'd0 : 64'h8000_0000_0000_0000;
            1: return divisor ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom(), 32'h8000_0000};
            2: return {$urandom(), 32'h0000_0000};
            3: return 64'($urandom_range(0, 300));
            4: return {$urandom(), 32'hFFFF_FFFF};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Behavioural divider: random accept delay, random latency, junk in
    // the upper word of W results.
    // ------------------------------------------------------------------
    initial begin : divider
        bit          dv_busy;
        int          dv_cnt;
        logic [63:0] dv_res;
        logic [63:0] r;
        dv_busy = 1'b0;
        dv_cnt  = 0;
        dv_res  = '0;
        bus.div_in_ready  = 1'b0;
        bus.div_out_valid = 1'b0;
        bus.div_result    = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.div_out_valid = 1'b0;
            bus.div_in_ready  = 1'b0;
            if (rst) begin
                dv_busy = 1'b0;
            end else if (dv_busy) begin
                if (dv_cnt == 0) begin
                    bus.div_out_valid = 1'b1;
                    bus.div_result    = dv_res;
                    dv_busy           = 1'b0;
                end else begin
                    dv_cnt--;
                end
            end else if (bus.div_in_valid && !bus.flush && !div_hold &&
                         $urandom_range(0, 2) != 0) begin
                bus.div_in_ready = 1'b1;
                div_accepts++;
                check1("div_saw_corner_op",
                       is_corner(bus.div_src1, bus.div_src2, bus.div_is_w, bus.div_aluctr), 1'b0);
                r       = ref_div(bus.div_src1, bus.div_src2, bus.div_is_w, bus.div_aluctr);
                dv_res  = bus.div_is_w ? {$urandom(), r[31:0]} : r;
                dv_cnt  = $urandom_range(lat_lo, lat_hi);
                dv_busy = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compare on every response handshake that is not killed
    // ------------------------------------------------------------------
    initial begin : monitor
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && bus.rsp_valid && bus.rsp_ready && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    fail("rsp_without_expected_op");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", bus.rsp_result, e[63:0]);
                    check("rsp_tag", 64'(bus.rsp_tag), 64'(e[EW-1:64]));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic w,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag,
                        output int waited);
        waited        = 0;
        bus.req_valid = 1'b1;
        bus.req_src1  = a;
        bus.req_src2  = b;
        bus.req_is_w  = w;
        bus.req_op    = op;
        bus.req_tag   = tag;
        #1;
        while (!bus.req_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.req_ready) fail("accept_timeout");
        else exp_q.push_back({tag, ref_div(a, b, w, op)});
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic finish_op();
        int n;
        n = 0;
        bus.rsp_ready = 1'b1;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.rsp_ready = 1'b0;
        if (busy) fail("finish_timeout");
    endtask

    task automatic wait_div_out();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (bus.div_out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) fail("div_out_timeout");
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : driver
        int w;
        int acc0;
        int n;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_src1  = '0;
        bus.req_src2  = '0;
        bus.req_is_w  = 1'b0;
        bus.req_op    = '0;
        bus.req_tag   = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check1("rst_req_ready", bus.req_ready, 1'b1);
        check1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_div_in_valid", bus.div_in_valid, 1'b0);
        check("rst_rsp_result", bus.rsp_result, 64'd0);
        check("rst_div_src1", bus.div_src1, 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        rst = 1'b0;
        @(negedge clk);

`ifdef DIV_RESULT_CACHE_EN
        // REM 77/10 through the divider, then an identical op from the cache
        send(64'd77, 64'd10, 1'b0, 2'b10, 5'd1, w);
        finish_op();
        acc0 = div_accepts;
        send(64'd77, 64'd10, 1'b0, 2'b10, 5'd2, w);
        check1("cache_hit_fast", bus.rsp_valid, 1'b1);
        check("cache_hit_result", bus.rsp_result, 64'd7);
        check1("cache_hit_no_issue", bus.div_in_valid, 1'b0);
        finish_op();
        check("cache_hit_div_untouched", 64'(div_accepts), 64'(acc0));
        send(64'd77, 64'd11, 1'b0, 2'b10, 5'd3, w);
        check1("cache_miss_issue", bus.div_in_valid, 1'b1);
        finish_op();
`endif

        // DIV 100 / -7 through the divider, then held for 5 cycles
        send(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 2'b00, 5'd3, w);
        check1("div_issue", bus.div_in_valid, 1'b1);
        wait_div_out();
        @(negedge clk);
        check1("div_rsp_latency", bus.rsp_valid, 1'b1);
        check("div_result_m14", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFF2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("hold_valid", bus.rsp_valid, 1'b1);
            check("hold_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFF2);
            check("hold_tag", 64'(bus.rsp_tag), 64'd3);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check1("hold_release_idle", busy, 1'b0);
        check1("hold_release_ready", bus.req_ready, 1'b1);

        // REMUW by zero: fast path, sext of low word
        acc0 = div_accepts;
        send(64'h1_0000_0005, 64'd0, 1'b1, 2'b11, 5'd7, w);
        check1("remuw_zero_fast", bus.rsp_valid, 1'b1);
        check1("remuw_zero_no_issue", bus.div_in_valid, 1'b0);
        check("remuw_zero_result", bus.rsp_result, 64'd5);
        finish_op();
        check("remuw_zero_div_untouched", 64'(div_accepts), 64'(acc0));

        // DIVW signed overflow: fast path
        send(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 2'b00, 5'd8, w);
        check1("divw_ovf_fast", bus.rsp_valid, 1'b1);
        check("divw_ovf_result", bus.rsp_result, 64'hFFFF_FFFF_8000_0000);
        finish_op();

        // DIVU 64/8 flushed 10 cycles after issue: drained, never answered
        lat_lo = 30;
        lat_hi = 30;
        send(64'd64, 64'd8, 1'b0, 2'b01, 5'd9, w);
        repeat (9) @(negedge clk);
        check("drain_pre_state", 64'(dbg_state), 64'(BUSY));
        bus.flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        bus.flush = 1'b0;
        check("drain_state", 64'(dbg_state), 64'(DRAIN));
        n = 0;
        while (n < 100) begin
            #2;
            if (bus.div_out_valid) break;
            check1("drain_req_ready", bus.req_ready, 1'b0);
            check1("drain_rsp_valid", bus.rsp_valid, 1'b0);
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("drain_timeout");
        @(negedge clk);
        check1("drain_end_ready", bus.req_ready, 1'b1);
        check1("drain_end_rsp_valid", bus.rsp_valid, 1'b0);
        lat_lo = 0;
        lat_hi = 12;
        send(64'd1000, 64'd3, 1'b0, 2'b01, 5'd10, w);
        check("drain_next_accept_wait", 64'(w), 64'd0);
        finish_op();

        // Flush in ISSUE: divider never sees the op
        div_hold = 1'b1;
        acc0 = div_accepts;
        send(64'd500, 64'd7, 1'b0, 2'b00, 5'd11, w);
        @(negedge clk);
        check("issue_state", 64'(dbg_state), 64'(ISSUE));
        bus.flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        bus.flush = 1'b0;
        div_hold  = 1'b0;
        check1("issue_flush_idle", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("issue_flush_div_untouched", 64'(div_accepts), 64'(acc0));
        check1("issue_flush_no_rsp", bus.rsp_valid, 1'b0);

        // Flush beats a same-cycle request
        bus.req_valid = 1'b1;
        bus.req_src1  = 64'd9;
        bus.req_src2  = 64'd3;
        bus.flush     = 1'b1;
        #1;
        check1("flush_blocks_ready", bus.req_ready, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check1("flush_blocks_accept", busy, 1'b0);

        // Flush in DONE with rsp_ready high: result dropped
        send(64'd5, 64'd0, 1'b0, 2'b00, 5'd12, w);
        check1("done_flush_pre", bus.rsp_valid, 1'b1);
        bus.flush     = 1'b1;
        bus.rsp_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        check1("done_flush_idle", busy, 1'b0);
        check1("done_flush_no_rsp", bus.rsp_valid, 1'b0);

        // Reset in the middle of a divider op
        lat_lo = 30;
        lat_hi = 30;
        send(64'd12345, 64'd67, 1'b0, 2'b00, 5'd13, w);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        check1("mid_rst_ready", bus.req_ready, 1'b1);
        check1("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        lat_lo = 0;
        lat_hi = 12;
        @(negedge clk);

        // Random ops with random backpressure and occasional flushes
        for (int k = 0; k < 150; k++) begin
            send(rnd_operand(1'b0), rnd_operand(1'b1), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), TAG_W'($urandom_range(0, 31)), w);
            n = 0;
            while (busy && n < 400) begin
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
                bus.flush     = ($urandom_range(0, 24) == 0);
                if (bus.flush) exp_q.delete();
                @(negedge clk);
                n++;
            end
            bus.flush     = 1'b0;
            bus.rsp_ready = 1'b0;
            if (busy) fail("random_op_timeout");
            check("random_queue_empty", 64'(exp_q.size()), 64'd0);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
